hazard_unit_mc: RTL and testbench

//  Pipeline hazard controller for the 5-stage core with multi-cycle execution support: M/W forwarding,

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hz_lat_cnt.sv | 59 +++++
 rtl/hazard_unit_mc.sv | 138 +++++++++++++
 tb/tb_hazard_unit_mc.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller: forwarding mux
// selects, the ResultSrc code that marks a load, and the latency-counter states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand forwarded from W
  localparam logic [1:0] FWD_M  = 2'b10;  // operand forwarded from M

  localparam logic [1:0] RES_LOAD = 2'b01;  // ResultSrc value of a load

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_BUSY = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/hz_lat_cnt.sv
// Occupancy counter for a multi-cycle unit. An op holds its stage for LAT
// cycles. busy_stall asks for that stage to be held while the op still has
// cycles left. adv says the stage is free to move on, which is what lets a
// finished op release the counter.
module hz_lat_cnt
  import hazard_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       adv,
  output logic       busy_stall,
  output cnt_state_e state_o
);

  localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam bit MULTI = (LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = (LAT > 1) ? CW'(LAT - 2) : '0;

  cnt_state_e    state_q;
  logic [CW-1:0] cnt_q;

  // Counter FSM. IDLE arms on a new op. BUSY counts down, holds at 0, and
  // returns to IDLE once the stage advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CNT_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        CNT_IDLE: begin
          if (start && MULTI) begin
            state_q <= CNT_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        CNT_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (adv) begin
            state_q <= CNT_IDLE;
          end
        end
        default: state_q <= CNT_IDLE;
      endcase
    end
  end

  // A fresh op stalls if it needs more than one cycle. A running op stalls
  // until its last cycle.
  always_comb begin
    busy_stall = start & ((state_q == CNT_IDLE) ? MULTI : (cnt_q != '0));
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core with a multi-cycle MUL/DIV in E and
// a multi-cycle data memory in M. It handles M/W forwarding, load-use stalls
// (or full RAW stalls when forwarding is disabled) and mispredict flushes.
// Priority, highest first: memory stall, MUL/DIV stall, decode hazard.
// A mispredict resolving in a free E stage squashes D. Any decode hazard
// raised by that wrong-path D instruction is therefore dropped, so D is never
// both flushed and held in the same cycle.
// md_state_o and mem_state_o expose the two counter FSMs for observation.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MD_LAT  = 4,
  parameter int MEM_LAT = 1,
  parameter int FWD_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] Rs1D,
  input  logic [RA_W-1:0] Rs2D,
  input  logic [RA_W-1:0] Rs1E,
  input  logic [RA_W-1:0] Rs2E,
  input  logic [RA_W-1:0] RdE,
  input  logic [RA_W-1:0] RdM,
  input  logic [RA_W-1:0] RdW,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcE,
  input  logic            MdE,
  input  logic            MemReqM,
  input  logic            MispredE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushM,
  output logic            FlushW,
  output logic            md_state_o,
  output logic            mem_state_o
);

  // Forwarding select for one E source. The newer result in M wins over W.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic rw_m, input logic [RA_W-1:0] rd_m,
                                         input logic rw_w, input logic [RA_W-1:0] rd_w);
    if (rw_m && (rd_m != '0) && (rd_m == rs)) return FWD_M;
    if (rw_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

  // True when a writing stage targets one of the D sources.
  function automatic logic raw_hit(input logic rw, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2);
    return rw && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  logic [1:0] fwd_a, fwd_b;
  logic       lwstall, rawstall, dstall;
  logic       md_stall, mem_stall;
  logic       stall_e_int, stall_m_int;
  logic       md_adv, mem_adv;
  logic       redirect, d_hz;
  logic       stall_fd, flush_e_int, flush_m_int, flush_w_int;
  cnt_state_e md_state, mem_state;

  // Forwarding muxes and the decode-stage hazard for the chosen forwarding mode.
  always_comb begin
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    lwstall  = (ResultSrcE == RES_LOAD) && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    rawstall = raw_hit(RegWriteE, RdE, Rs1D, Rs2D) ||
               raw_hit(RegWriteM, RdM, Rs1D, Rs2D) ||
               raw_hit(RegWriteW, RdW, Rs1D, Rs2D);
    if (FWD_EN != 0) begin
      fwd_a  = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      fwd_b  = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      dstall = lwstall;
    end else begin
      dstall = rawstall;
    end
  end

  assign md_adv  = ~stall_e_int;
  assign mem_adv = ~stall_m_int;

  hz_lat_cnt #(.LAT(MD_LAT)) u_md_cnt (
    .clk        (clk),
    .rst        (rst),
    .start      (MdE),
    .adv        (md_adv),
    .busy_stall (md_stall),
    .state_o    (md_state)
  );

  hz_lat_cnt #(.LAT(MEM_LAT)) u_mem_cnt (
    .clk        (clk),
    .rst        (rst),
    .start      (MemReqM),
    .adv        (mem_adv),
    .busy_stall (mem_stall),
    .state_o    (mem_state)
  );

  // Stall/flush priority. A flush is only ever asserted on a stage that is moving.
  always_comb begin
    stall_m_int = mem_stall;
    stall_e_int = mem_stall | md_stall;
    redirect    = MispredE & ~stall_e_int;
    d_hz        = dstall & ~redirect;
    stall_fd    = stall_e_int | d_hz;
    flush_e_int = (d_hz & ~stall_e_int) | redirect;
    flush_m_int = md_stall & ~mem_stall;
    flush_w_int = mem_stall;
  end

  // During reset every control output is forced low.
  always_comb begin
    ForwardAE = rst ? fwd_a : FWD_RF;
    ForwardBE = rst ? fwd_b : FWD_RF;
    StallF    = rst & stall_fd;
    StallD    = rst & stall_fd;
    StallE    = rst & stall_e_int;
    StallM    = rst & stall_m_int;
    FlushD    = rst & redirect;
    FlushE    = rst & flush_e_int;
    FlushM    = rst & flush_m_int;
    FlushW    = rst & flush_w_int;
  end

  assign md_state_o  = (md_state == CNT_BUSY);
  assign mem_state_o = (mem_state == CNT_BUSY);

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc. Three configurations share one input stream:
//   u0: MD_LAT=4 MEM_LAT=1 FWD_EN=1
//   u1: MD_LAT=4 MEM_LAT=3 FWD_EN=1
//   u2: MD_LAT=1 MEM_LAT=1 FWD_EN=0
// The reference model tracks how many cycles each multi-cycle op still owns
// its stage, then applies the stall/flush rules directly.
// Output packing is {FwdA, FwdB, StallF, StallD, StallE, StallM,
// FlushD, FlushE, FlushM, FlushW}.
// Inputs are driven after the falling edge and sampled 1 ns later.
module tb_hazard_unit_mc;

  localparam int NI = 3;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       MdE, MemReqM, MispredE;

  logic [11:0] obs [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fm, fw, mds, mems;
    hazard_unit_mc #(
      .RA_W(5), .MD_LAT((g == 2) ? 1 : 4), .MEM_LAT((g == 1) ? 3 : 1), .FWD_EN((g == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .MdE(MdE), .MemReqM(MemReqM), .MispredE(MispredE),
      .ForwardAE(fa), .ForwardBE(fb),
      .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
      .FlushD(fd), .FlushE(fe), .FlushM(fm), .FlushW(fw),
      .md_state_o(mds), .mem_state_o(mems)
    );
    assign obs[g] = {fa, fb, sf, sd, se, sm, fd, fe, fm, fw};
  end

  function automatic int md_lat(int k);
    return (k == 2) ? 1 : 4;
  endfunction
  function automatic int mem_lat(int k);
    return (k == 1) ? 3 : 1;
  endfunction
  function automatic bit fwd_en(int k);
    return (k != 2);
  endfunction

  // Reference model state: cycles the current op still occupies the stage (0 = none).
  int md_left [NI];
  int mem_left[NI];
  bit ses[NI], sms[NI];

  // Scoreboard.
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
    n_checks++;
    assert (o === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%03h expected=%03h", tag, o, e);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic rw, input logic [4:0] rd);
    return rw && rd != 0 && (rd == Rs1D || rd == Rs2D);
  endfunction

  function automatic logic [11:0] model(input int k, output bit se_o, output bit sm_o);
    logic [1:0] fa, fb;
    bit dh, mds, mems, redir;
    bit sf, sd, se, sm, fd, fe, fm, fw;
    int eff;
    fa = 2'b00; fb = 2'b00;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0; fw = 0;
    se_o = 0; sm_o = 0;
    if (!rst) return 12'h000;
    if (fwd_en(k)) begin
      fa = fwd_of(Rs1E);
      fb = fwd_of(Rs2E);
      dh = (ResultSrcE == 2'b01) && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    end else begin
      dh = reads(RegWriteE, RdE) || reads(RegWriteM, RdM) || reads(RegWriteW, RdW);
    end
    eff  = (md_left[k] == 0) ? md_lat(k) : md_left[k];
    mds  = MdE && eff > 1;
    eff  = (mem_left[k] == 0) ? mem_lat(k) : mem_left[k];
    mems = MemReqM && eff > 1;
    if (mems) begin
      sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
    end else if (mds) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end
    redir = MispredE && !se;
    if (!se && dh && !redir) begin
      sf = 1; sd = 1; fe = 1;
    end
    if (redir) begin
      fd = 1; fe = 1;
    end
    se_o = se; sm_o = sm;
    return {fa, fb, sf, sd, se, sm, fd, fe, fm, fw};
  endfunction

  // Driver tasks.
  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    MdE = 0; MemReqM = 0; MispredE = 0;
  endtask

  // Settle, then check all instances against the model.
  task automatic step(input string tag);
    bit se, sm;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_q.push_back(model(k, se, sm));
      ses[k] = se;
      sms[k] = sm;
    end
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s/u%0d", tag, k), obs[k], exp_q.pop_front());
    end
  endtask

  // Clock edge: advance the model's occupancy counters.
  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        md_left[k]  = 0;
        mem_left[k] = 0;
      end else begin
        if (md_left[k] == 0 && MdE) md_left[k] = md_lat(k);
        if (md_left[k] > 1) md_left[k]--;
        else if (md_left[k] == 1 && !ses[k]) md_left[k] = 0;
        if (mem_left[k] == 0 && MemReqM) mem_left[k] = mem_lat(k);
        if (mem_left[k] > 1) mem_left[k]--;
        else if (mem_left[k] == 1 && !sms[k]) mem_left[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      md_left[k] = 0; mem_left[k] = 0; ses[k] = 0; sms[k] = 0;
    end
    rst = 1'b0;
    set_idle();
    @(negedge clk);

    // Reset: inputs that would trigger everything still give all-zero outputs.
    MdE = 1; MispredE = 1; RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1;
    step("rst");
    check("rst_u0_zero", obs[0], 12'h000);
    check("rst_u1_zero", obs[1], 12'h000);
    advance();
    set_idle();
    step("rst_hold");
    advance();
    rst = 1'b1;
    step("rst_rel");
    advance();

    // ALU chain forwarding: M beats W; W alone; nothing.
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    step("fwd_mw");
    check("fwd_m_wins", {10'd0, obs[0][11:10]}, 12'h002);
    check("fwd_off", {10'd0, obs[2][11:10]}, 12'h000);
    advance();
    RdM = 0;
    step("fwd_w");
    check("fwd_w_only", {10'd0, obs[0][11:10]}, 12'h001);
    advance();
    RegWriteW = 0; Rs2E = 5;
    step("fwd_none");
    check("fwd_rd0", obs[0], 12'h000);
    advance();
    set_idle();

    // Load-use stall and the RdE=0 exemption.
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    step("lw");
    check("lw_stall", obs[0], 12'h0C4);
    advance();
    RdE = 0; Rs2D = 0;
    step("lw_rd0");
    check("lw_rd0_nostall", obs[0], 12'h000);
    advance();
    set_idle();

    // MD_LAT=4 with MdE held high: three stall cycles, one free, then it repeats.
    MdE = 1;
    for (int i = 0; i < 8; i++) begin
      step($sformatf("md%0d", i));
      check($sformatf("md_pat%0d", i), obs[0], (i % 4 == 3) ? 12'h000 : 12'h0E2);
      advance();
    end
    set_idle();
    step("md_done");
    advance();

    // MEM_LAT=3 with a mispredict waiting in E until the stall lifts.
    MemReqM = 1; MispredE = 1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("mem%0d", i));
      check($sformatf("mem_mp%0d", i), obs[1], (i == 2) ? 12'h00C : 12'h0F1);
      advance();
    end
    set_idle();
    step("mem_done");
    check("mem_mp_once", obs[1], 12'h000);
    advance();

    // No forwarding: RAW against W stalls D and the forward select stays 00.
    RdW = 3; RegWriteW = 1; Rs1D = 3; Rs1E = 3;
    step("raw");
    check("raw_stall", obs[2], 12'h0C4);
    check("raw_fwd_u0", obs[0], 12'h400);
    advance();
    set_idle();

    // Reset in the middle of a MUL/DIV op, then a fresh op sees the full latency.
    MdE = 1;
    step("md_pre0");
    advance();
    step("md_pre1");
    advance();
    rst = 1'b0;
    step("md_rst");
    check("md_rst_zero", obs[0], 12'h000);
    advance();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("md_fresh%0d", i));
      check($sformatf("md_fresh%0d", i), obs[0], (i == 3) ? 12'h000 : 12'h0E2);
      advance();
    end
    set_idle();
    step("idle");
    advance();

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) != 0);
      Rs1D       = 5'($urandom_range(0, 7));
      Rs2D       = 5'($urandom_range(0, 7));
      Rs1E       = 5'($urandom_range(0, 7));
      Rs2E       = 5'($urandom_range(0, 7));
      RdE        = 5'($urandom_range(0, 7));
      RdM        = 5'($urandom_range(0, 7));
      RdW        = 5'($urandom_range(0, 7));
      RegWriteE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      MdE        = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 3) == 0);
      MispredE   = ($urandom_range(0, 7) == 0);
      step($sformatf("rnd%0d", n));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
